mod_n_down_counter: RTL and testbench

Programmable modulo-N down counter. It is the counting-direction counterpart of the team's mod-2 up counter.
- Counts from MODULUS-1 down to 0.
- Supports parallel load, enable, auto-reload or one-shot mode, a terminal-count strobe and a registered wrap pulse.
- Used as a timer and tick divider feeding downstream control logic.

---
 rtl/counter_pkg.sv | 19 +
 rtl/mod_n_down_counter.sv | 74 +++++++
 tb/tb_mod_n_down_counter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: state encoding and the
// load-value clamp used when software hands us an out-of-range preset.
package counter_pkg;

    // Counter run state: RUN counts down, DONE is the parked one-shot state
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Clamp a requested load value into the legal range 0..modulus-1.
    // Anything at or above the modulus lands on the top of the range so a
    // bad preset still behaves like a full-length period.
    function automatic int unsigned clamp_load(input int unsigned val,
                                               input int unsigned modulus);
        return (val >= modulus) ? (modulus - 1) : val;
    endfunction

endpackage

// File: rtl/mod_n_down_counter.sv
// Programmable modulo-N down counter with parallel load, enable,
// auto-reload / one-shot selection, a combinational terminal-count strobe
// and registered wrap/done/busy flags. Used as a timer and tick divider.
module mod_n_down_counter
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    state_t state;

    // Count/state register: reset beats load, load beats enable; the zero
    // case is handled explicitly so the decrement can never underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= TOP;
            state <= ST_RUN;
            wrap  <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b1;
        end else if (load) begin
            count <= WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));
            state <= ST_RUN;
            wrap  <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b1;
        end else begin
            wrap <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (en) begin
                        if (count != '0) begin
                            count <= count - WIDTH'(1);
                        end else if (oneshot) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            count <= TOP;
                            wrap  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    count <= '0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Terminal count: a decrement from zero is being consumed this cycle
    assign tc = (count == '0) && en && (state == ST_RUN) && !load && !reset;

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Self-checking bench for mod_n_down_counter (MODULUS=10, WIDTH=4).
// Each step drives inputs on the falling edge, checks tc before the rising
// edge, queues the expected registered outputs and compares them after it.
module tb_mod_n_down_counter;

    logic       clk = 1'b0;
    logic       reset, en, load, oneshot;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc, wrap, done, busy;

    typedef struct {
        logic       r;
        logic       e;
        logic       l;
        logic [3:0] lv;
        logic       os;
        logic [3:0] ec;
        logic       et;
        logic       ew;
        logic       ed;
        logic       eb;
    } vec_t;

    typedef struct {
        int         step;
        logic [3:0] ec;
        logic       ew;
        logic       ed;
        logic       eb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests    = 0;
    int   failures = 0;
    int   stepNum  = 0;

    mod_n_down_counter #(.MODULUS(10), .WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .oneshot  (oneshot),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .done     (done),
        .busy     (busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkField(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, stepNum, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare the registered outputs
    task automatic checkOutput();
        exp_t x;
        if (sb.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL scoreboard step %0d: got empty queue expected entry", stepNum);
            return;
        end
        x = sb.pop_front();
        checkField("count", int'(count), int'(x.ec));
        checkField("wrap",  int'(wrap),  int'(x.ew));
        checkField("done",  int'(done),  int'(x.ed));
        checkField("busy",  int'(busy),  int'(x.eb));
    endtask

    // One clock of stimulus: tc is checked pre-edge, the rest post-edge
    task automatic applyStimulus(input logic r, input logic e, input logic l,
                                 input logic [3:0] lv, input logic os,
                                 input logic [3:0] ec, input logic et,
                                 input logic ew, input logic ed, input logic eb);
        exp_t x;
        @(negedge clk);
        stepNum++;
        reset    = r;
        en       = e;
        load     = l;
        load_val = lv;
        oneshot  = os;
        #1;
        checkField("tc", int'(tc), int'(et));
        x.step = stepNum;
        x.ec   = ec;
        x.ew   = ew;
        x.ed   = ed;
        x.eb   = eb;
        sb.push_back(x);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic l,
                                input logic [3:0] lv, input logic os,
                                input logic [3:0] ec, input logic et,
                                input logic ew, input logic ed, input logic eb);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.lv = lv; v.os = os;
        v.ec = ec; v.et = et; v.ew = ew; v.ed = ed; v.eb = eb;
        return v;
    endfunction

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; load_val = 4'd0; oneshot = 1'b0;

        // Reset, then free-run auto-reload through one wrap
        //            r  e  l  lv  os  cnt tc w  d  b
        vecs.push_back(mk(1, 0, 0, 0, 0, 9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 7, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 6, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 5, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 7, 0, 0, 0, 1));
        // Load at count 6 with en high: no decrement that cycle
        vecs.push_back(mk(0, 1, 0, 0, 0, 6, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 3, 0, 3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 1, 1, 0, 1));
        // Load clamping and the zero boundary
        vecs.push_back(mk(0, 0, 1, 12, 0, 9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 15, 0, 9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 10, 0, 9, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        // Load coinciding with a zero crossing: load wins, no wrap, no done
        vecs.push_back(mk(0, 1, 1, 4, 1, 4, 0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].lv, vecs[i].os,
                          vecs[i].ec, vecs[i].et, vecs[i].ew, vecs[i].ed, vecs[i].eb);
        end

        // One-shot expiry, parked in DONE, then reloaded
        applyStimulus(0, 0, 1, 2, 1, 2, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 5, 1, 5, 0, 0, 0, 1);

        // Reset mid-count with en high
        applyStimulus(0, 1, 0, 0, 0, 4, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 9, 0, 0, 0, 1);
        // Reset out of DONE
        applyStimulus(0, 0, 1, 1, 1, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 9, 0, 0, 0, 1);

        // Hold at zero with en low, then release
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 1, 0, 0, 0, 9, 1, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 8, 0, 0, 0, 1);

        // oneshot only matters at the crossing: high while counting, low at zero
        applyStimulus(0, 0, 1, 1, 1, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 9, 1, 1, 0, 1);

        tests++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
